// File: rtl/binary_to_gray_conv.sv
// binary_to_gray_conv: registered binary-to-Gray converter with decode echo and one-bit-change flag
//   clk          in   rising-edge clock
//   rst          in   synchronous active-high reset
//   in_valid     in   accept binary_in on this edge
//   binary_in    in   BITS-wide unsigned binary word
//   out_valid    out  a new result was accepted on the last edge
//   gray         out  registered Gray code of the last accepted word
//   binary_echo  out  binary decoded combinationally from gray
//   adj_one      out  gray differs from the previous valid gray in exactly one bit
//   first        out  result is the first valid one since reset
module binary_to_gray_conv #(
    parameter int BITS = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [BITS-1:0] binary_in,
    output logic            out_valid,
    output logic [BITS-1:0] gray,
    output logic [BITS-1:0] binary_echo,
    output logic            adj_one,
    output logic            first
);
    logic [BITS-1:0] gray_q, gray_d, diff;
    logic            valid_q, adj_q, adj_d, first_q, first_d, have_q;
    // gray_q only updates on valid results, so it doubles as the previous valid gray
    always_comb begin
        gray_d  = binary_in ^ (binary_in >> 1);
        diff    = gray_d ^ gray_q;
        adj_d   = have_q && (diff != '0) && ((diff & (diff - BITS'(1))) == '0);
        first_d = !have_q;
        // binary bit i is the XOR of all gray bits from i up to the MSB
        for (int i = 0; i < BITS; i++) binary_echo[i] = ^(gray_q >> i);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            gray_q  <= '0;
            valid_q <= 1'b0;
            adj_q   <= 1'b0;
            first_q <= 1'b0;
            have_q  <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                gray_q  <= gray_d;
                adj_q   <= adj_d;
                first_q <= first_d;
                have_q  <= 1'b1;
            end
        end
    end
    assign out_valid = valid_q;
    assign gray      = gray_q;
    assign adj_one   = adj_q;
    assign first     = first_q;
endmodule

// File: tb/tb_binary_to_gray_conv.sv
// tb_binary_to_gray_conv: randomized and directed scoreboard bench for binary_to_gray_conv
//   drives clk/rst/in_valid/binary_in, model pushes expectations, monitor pops and compares
module tb_binary_to_gray_conv;
    localparam int W = 8;
    typedef struct {
        logic [W-1:0] g;
        logic [W-1:0] e;
        logic         a;
        logic         f;
    } exp_t;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b1;
    logic [W-1:0] binary_in = 8'hFF;
    logic         out_valid, adj_one, first;
    logic [W-1:0] gray, binary_echo;
    exp_t         sb[$];
    exp_t         held = '{g: '0, e: '0, a: 1'b0, f: 1'b0};
    int           vectors = 0;
    int           miscompares = 0;
    logic         last_rst = 1'b0;
    logic         have = 1'b0;
    logic [W-1:0] prev_g = '0;
    logic [W-1:0] last_b = '0;

    binary_to_gray_conv #(.BITS(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .binary_in(binary_in),
        .out_valid(out_valid), .gray(gray), .binary_echo(binary_echo),
        .adj_one(adj_one), .first(first)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] to_gray(input logic [W-1:0] b);
        logic [W-1:0] g;
        g[W-1] = b[W-1];
        for (int i = W - 2; i >= 0; i--) g[i] = b[i+1] != b[i];
        return g;
    endfunction

    function automatic int bits_set(input logic [W-1:0] x);
        int n = 0;
        for (int i = 0; i < W; i++) n += int'(x[i]);
        return n;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: records what each edge should produce
    always @(posedge clk) begin
        if (rst) begin
            last_rst = 1'b1;
            have = 1'b0;
            prev_g = '0;
        end else begin
            last_rst = 1'b0;
            if (in_valid) begin
                exp_t x;
                x.g = to_gray(binary_in);
                x.e = binary_in;
                x.a = have && bits_set(x.g ^ prev_g) == 1;
                x.f = !have;
                sb.push_back(x);
                prev_g = x.g;
                have = 1'b1;
            end
        end
    end

    // monitor: samples just after each edge
    always @(posedge clk) begin
        #1;
        if (last_rst) begin
            check("rst_gray", 32'(gray), 0);
            check("rst_echo", 32'(binary_echo), 0);
            check("rst_valid", 32'(out_valid), 0);
            check("rst_adj", 32'(adj_one), 0);
            check("rst_first", 32'(first), 0);
            held = '{g: '0, e: '0, a: 1'b0, f: 1'b0};
        end else if (out_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", 32'(out_valid), 0);
            end else begin
                held = sb.pop_front();
                check("gray", 32'(gray), 32'(held.g));
                check("echo", 32'(binary_echo), 32'(held.e));
                check("adj_one", 32'(adj_one), 32'(held.a));
                check("first", 32'(first), 32'(held.f));
            end
        end else begin
            check("missing_valid", 32'(sb.size()), 0);
            check("hold_gray", 32'(gray), 32'(held.g));
            check("hold_echo", 32'(binary_echo), 32'(held.e));
            check("hold_adj", 32'(adj_one), 32'(held.a));
            check("hold_first", 32'(first), 32'(held.f));
        end
    end

    task automatic drive(input logic r, input logic v, input logic [W-1:0] b);
        @(negedge clk);
        rst = r;
        in_valid = v;
        binary_in = b;
        if (v) last_b = b;
    endtask

    initial begin
        logic [W-1:0] spot[7] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h7F, 8'h80, 8'hFF};
        drive(1, 1, 8'hFF);
        drive(1, 1, 8'hFF);
        foreach (spot[k]) begin
            drive(0, 1, spot[k]);
            if (k % 2 == 1) drive(0, 0, 8'hA5);
        end
        drive(1, 0, 0);
        for (int i = 0; i < 256; i++) drive(0, 1, W'(i));
        drive(0, 1, 8'hFF);
        drive(0, 1, 8'h00);
        drive(0, 1, 8'h00);
        drive(0, 1, 8'h05);
        drive(0, 1, 8'h05);
        drive(0, 1, 8'h05);
        drive(0, 0, 8'h3C);
        drive(0, 0, 8'hC3);
        drive(0, 1, 8'h05);
        for (int i = 0; i <= 16; i++) drive(0, 1, W'(i));
        drive(1, 1, 8'h77);
        drive(0, 1, 8'h11);
        drive(0, 1, 8'h12);
        for (int i = 0; i < 400; i++) begin
            logic [W-1:0] b;
            b = ($urandom_range(0, 1) == 1) ? last_b + 1'b1 : W'($urandom);
            drive($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, b);
        end
        drive(0, 0, 0);
        drive(0, 0, 0);
        drive(0, 0, 0);
        check("queue_drained", 32'(sb.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/binary_to_gray_conv.md
Name: binary_to_gray_conv

Overview:
- Registered binary-to-Gray code converter with a one-cycle pipeline stage.
- Converts a BITS-wide unsigned binary word into its reflected-binary Gray code.
- Also reconstructs the binary value from the registered Gray word, so the round trip can be self-checked.
- Flags whether consecutive valid Gray outputs differ in exactly one bit; used on counter and pointer paths that must cross clock domains safely.

Parameters:
- BITS, default 8, data width of binary input and Gray output (legal range 2..32).

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous active-high reset.
- in_valid, input, 1, binary_in is sampled on a clk edge when high.
- binary_in, input, BITS, unsigned binary word to convert.
- out_valid, output, 1, gray/binary_echo/adj_one hold a new result this cycle.
- gray, output, BITS, registered Gray code of the last accepted binary_in.
- binary_echo, output, BITS, binary value decoded from the registered gray.
- adj_one, output, 1, current gray differs from previous valid gray in exactly one bit.
- first, output, 1, current result is the first valid result since reset (no predecessor).

Behaviour:
- Conversion: gray[BITS-1] = binary_in[BITS-1]; gray[i] = binary_in[i+1] XOR binary_in[i] for i = BITS-2..0. Equivalently, gray = binary_in XOR (binary_in >> 1).
- Decode: binary_echo[BITS-1] = gray[BITS-1]; binary_echo[i] = binary_echo[i+1] XOR gray[i]. This is a combinational prefix-XOR from the registered gray.
  - Invariant: binary_echo == the accepted binary_in whenever out_valid = 1.
- Latency: exactly 1 cycle. binary_in accepted at edge N appears on gray at edge N (registered) with out_valid = 1 for that cycle.
- in_valid = 0 at an edge:
  - out_valid drops to 0 for the next cycle.
  - gray, binary_echo, adj_one and first hold their previous values.
- No backpressure; every in_valid = 1 cycle is accepted.
- Adjacency check:
  - prev_gray holds the last valid gray.
  - adj_one = 1 iff popcount(gray XOR prev_gray) == 1.
  - Identical consecutive inputs give adj_one = 0.
  - adj_one is computed and registered alongside gray.
- First result after reset: first = 1 and adj_one = 0. Later valid results have first = 0. first is cleared only by reset.
- Wrap-around: all-ones binary followed by zero gives a one-bit Gray change (MSB only), so adj_one = 1.
- Reset (synchronous, rst = 1 at edge):
  - gray = 0, binary_echo = 0, out_valid = 0, adj_one = 0, first = 0, prev_gray = 0.
  - The internal "have previous" flag is cleared.
  - rst has priority over in_valid in the same cycle; the input is discarded.
- Reset mid-stream: the next valid input after rst deasserts behaves as the first result (first = 1).
- Outputs change only on clk rising edges, except binary_echo, which is a combinational function of the gray register.

Test Plan:
- Reset: hold rst = 1 with in_valid = 1 and binary_in = 0xFF -> gray = 0x00, out_valid = 0, first = 0, adj_one = 0.
- Spot values (BITS = 8), one cycle after acceptance:
  - 0x00 -> 0x00
  - 0x01 -> 0x01
  - 0x02 -> 0x03
  - 0x03 -> 0x02
  - 0x7F -> 0x40
  - 0x80 -> 0xC0
  - 0xFF -> 0x80
  - In every case binary_echo equals the input.
- Full sweep: binary_in = 0..255 in consecutive cycles -> first = 1 on input 0 only; adj_one = 1 on every later result; binary_echo == input each cycle.
- Wrap-around: 0xFF then 0x00 -> gray 0x80 then 0x00, adj_one = 1 on the second result.
- Non-adjacent and hold:
  - 0x00 then 0x05 -> gray 0x07, adj_one = 0.
  - Repeating 0x05 -> adj_one = 0.
  - in_valid = 0 gaps -> out_valid = 0 and outputs held.
- Reset mid-stream: sweep to 0x10, pulse rst, then apply 0x11 -> gray = 0x19, first = 1, adj_one = 0.
